// File: rtl/alu_rs.sv
// alu_rs: reservation station in front of the ALU.
// Holds decoded ALU/branch/jump instructions until both operands are known.
// It snoops the ALU and load/store result buses to pick up missing operands,
// and issues at most one operand-complete entry per cycle.
//
// Dispatch handshake: a request is accepted on a rising edge where
// ready & dec_valid & !rs_full. While rs_full is high the request is ignored
// and the decoder must hold it. The ALU side has no backpressure: work is a
// one-cycle valid pulse per issued instruction.
module alu_rs #(
    parameter int RS_SIZE = 16,
    parameter int OP_W    = 6,
    parameter int ROB_W   = 4,
    parameter int XLEN    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    input  logic              flush,
    input  logic              dec_valid,
    input  logic [OP_W-1:0]   dec_op,
    input  logic [XLEN-1:0]   dec_imm,
    input  logic [XLEN-1:0]   dec_pc,
    input  logic [ROB_W-1:0]  dec_robpos,
    input  logic              dec_q1_busy,
    input  logic [ROB_W-1:0]  dec_q1,
    input  logic [XLEN-1:0]   dec_v1,
    input  logic              dec_q2_busy,
    input  logic [ROB_W-1:0]  dec_q2,
    input  logic [XLEN-1:0]   dec_v2,
    output logic              rs_full,
    input  logic              alu_flag,
    input  logic [ROB_W-1:0]  alu_robpos,
    input  logic [XLEN-1:0]   alu_val,
    input  logic              lsb_flag,
    input  logic [ROB_W-1:0]  lsb_robpos,
    input  logic [XLEN-1:0]   lsb_val,
    output logic              work,
    output logic [OP_W-1:0]   op,
    output logic [XLEN-1:0]   imm,
    output logic [XLEN-1:0]   pc,
    output logic [ROB_W-1:0]  robpos,
    output logic [XLEN-1:0]   rs1,
    output logic [XLEN-1:0]   rs2
);

    localparam int IDX_W = $clog2(RS_SIZE);

    // Entry storage; only the busy bits need a reset value.
    logic [RS_SIZE-1:0] e_busy;
    logic [RS_SIZE-1:0] e_q1_busy;
    logic [RS_SIZE-1:0] e_q2_busy;
    logic [OP_W-1:0]    e_op     [RS_SIZE];
    logic [XLEN-1:0]    e_imm    [RS_SIZE];
    logic [XLEN-1:0]    e_pc     [RS_SIZE];
    logic [ROB_W-1:0]   e_robpos [RS_SIZE];
    logic [ROB_W-1:0]   e_q1     [RS_SIZE];
    logic [ROB_W-1:0]   e_q2     [RS_SIZE];
    logic [XLEN-1:0]    e_v1     [RS_SIZE];
    logic [XLEN-1:0]    e_v2     [RS_SIZE];

    logic             iss_found;
    logic [IDX_W-1:0] iss_idx;
    logic [IDX_W-1:0] free_idx;
    logic             d_q1_busy;
    logic             d_q2_busy;
    logic [XLEN-1:0]  d_v1;
    logic [XLEN-1:0]  d_v2;

    assign rs_full = &e_busy;

    // Lowest-index ready entry for issue and lowest-index free slot for dispatch.
    always_comb begin
        iss_found = 1'b0;
        iss_idx   = '0;
        free_idx  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (e_busy[i] && !e_q1_busy[i] && !e_q2_busy[i]) begin
                iss_found = 1'b1;
                iss_idx   = i[IDX_W-1:0];
            end
            if (!e_busy[i]) begin
                free_idx = i[IDX_W-1:0];
            end
        end
    end

    // Forward a same-cycle broadcast into the dispatched operands (ALU bus first).
    always_comb begin
        d_q1_busy = dec_q1_busy;
        d_v1      = dec_v1;
        d_q2_busy = dec_q2_busy;
        d_v2      = dec_v2;
        if (dec_q1_busy) begin
            if (alu_flag && alu_robpos == dec_q1) begin
                d_q1_busy = 1'b0;
                d_v1      = alu_val;
            end else if (lsb_flag && lsb_robpos == dec_q1) begin
                d_q1_busy = 1'b0;
                d_v1      = lsb_val;
            end
        end
        if (dec_q2_busy) begin
            if (alu_flag && alu_robpos == dec_q2) begin
                d_q2_busy = 1'b0;
                d_v2      = alu_val;
            end else if (lsb_flag && lsb_robpos == dec_q2) begin
                d_q2_busy = 1'b0;
                d_v2      = lsb_val;
            end
        end
    end

    // Issue, wakeup and dispatch; flush empties the station, ready low freezes all.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_busy <= '0;
            work   <= 1'b0;
            op     <= '0;
            imm    <= '0;
            pc     <= '0;
            robpos <= '0;
            rs1    <= '0;
            rs2    <= '0;
        end else if (ready) begin
            if (flush) begin
                e_busy <= '0;
                work   <= 1'b0;
            end else begin
                if (iss_found) begin
                    work            <= 1'b1;
                    op              <= e_op[iss_idx];
                    imm             <= e_imm[iss_idx];
                    pc              <= e_pc[iss_idx];
                    robpos          <= e_robpos[iss_idx];
                    rs1             <= e_v1[iss_idx];
                    rs2             <= e_v2[iss_idx];
                    e_busy[iss_idx] <= 1'b0;
                end else begin
                    work <= 1'b0;
                end

                for (int i = 0; i < RS_SIZE; i++) begin
                    if (e_busy[i] && e_q1_busy[i]) begin
                        if (alu_flag && alu_robpos == e_q1[i]) begin
                            e_q1_busy[i] <= 1'b0;
                            e_v1[i]      <= alu_val;
                        end else if (lsb_flag && lsb_robpos == e_q1[i]) begin
                            e_q1_busy[i] <= 1'b0;
                            e_v1[i]      <= lsb_val;
                        end
                    end
                    if (e_busy[i] && e_q2_busy[i]) begin
                        if (alu_flag && alu_robpos == e_q2[i]) begin
                            e_q2_busy[i] <= 1'b0;
                            e_v2[i]      <= alu_val;
                        end else if (lsb_flag && lsb_robpos == e_q2[i]) begin
                            e_q2_busy[i] <= 1'b0;
                            e_v2[i]      <= lsb_val;
                        end
                    end
                end

                // The free slot is never the issuing slot, so no write conflict.
                if (dec_valid && !rs_full) begin
                    e_busy[free_idx]    <= 1'b1;
                    e_op[free_idx]      <= dec_op;
                    e_imm[free_idx]     <= dec_imm;
                    e_pc[free_idx]      <= dec_pc;
                    e_robpos[free_idx]  <= dec_robpos;
                    e_q1_busy[free_idx] <= d_q1_busy;
                    e_q1[free_idx]      <= dec_q1;
                    e_v1[free_idx]      <= d_v1;
                    e_q2_busy[free_idx] <= d_q2_busy;
                    e_q2[free_idx]      <= dec_q2;
                    e_v2[free_idx]      <= d_v2;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed bench for the ALU reservation station.
// Expected issued instructions are queued when dispatched and checked in
// order whenever the station produces a new work pulse.
module tb_alu_rs;

    localparam int OP_W  = 6;
    localparam int ROB_W = 4;
    localparam int XLEN  = 32;
    localparam int PW    = OP_W + ROB_W + 4 * XLEN;

    localparam logic [OP_W-1:0] OP_ADD = 6'h01;
    localparam logic [OP_W-1:0] OP_BEQ = 6'h10;
    localparam logic [OP_W-1:0] OP_SUB = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL = 6'h20;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             ready = 1'b1;
    logic             flush = 1'b0;
    logic             dec_valid = 1'b0;
    logic [OP_W-1:0]  dec_op = '0;
    logic [XLEN-1:0]  dec_imm = '0;
    logic [XLEN-1:0]  dec_pc = '0;
    logic [ROB_W-1:0] dec_robpos = '0;
    logic             dec_q1_busy = 1'b0;
    logic [ROB_W-1:0] dec_q1 = '0;
    logic [XLEN-1:0]  dec_v1 = '0;
    logic             dec_q2_busy = 1'b0;
    logic [ROB_W-1:0] dec_q2 = '0;
    logic [XLEN-1:0]  dec_v2 = '0;
    logic             rs_full;
    logic             alu_flag = 1'b0;
    logic [ROB_W-1:0] alu_robpos = '0;
    logic [XLEN-1:0]  alu_val = '0;
    logic             lsb_flag = 1'b0;
    logic [ROB_W-1:0] lsb_robpos = '0;
    logic [XLEN-1:0]  lsb_val = '0;
    logic             work;
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [ROB_W-1:0] robpos;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;

    int n_cmp = 0;
    int n_bad = 0;
    logic [PW-1:0] exp_q[$];
    logic adv = 1'b0;

    alu_rs #(.RS_SIZE(16), .OP_W(OP_W), .ROB_W(ROB_W), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .ready(ready), .flush(flush),
        .dec_valid(dec_valid), .dec_op(dec_op), .dec_imm(dec_imm), .dec_pc(dec_pc),
        .dec_robpos(dec_robpos), .dec_q1_busy(dec_q1_busy), .dec_q1(dec_q1),
        .dec_v1(dec_v1), .dec_q2_busy(dec_q2_busy), .dec_q2(dec_q2), .dec_v2(dec_v2),
        .rs_full(rs_full), .alu_flag(alu_flag), .alu_robpos(alu_robpos),
        .alu_val(alu_val), .lsb_flag(lsb_flag), .lsb_robpos(lsb_robpos),
        .lsb_val(lsb_val), .work(work), .op(op), .imm(imm), .pc(pc),
        .robpos(robpos), .rs1(rs1), .rs2(rs2)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // Remember whether the last edge was an advancing one, so a held work is not a new issue.
    always @(posedge clk) adv <= ready && !reset;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: each new work pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (work && adv) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $error("FAIL unexpected_issue: observed robpos %0h required no issue", robpos);
            end else begin
                logic [PW-1:0] e;
                e = exp_q.pop_front();
                n_cmp++;
                assert ({op, robpos, pc, imm, rs1, rs2} === e) else begin
                    n_bad++;
                    $error("FAIL issue_payload: observed %h required %h", {op, robpos, pc, imm, rs1, rs2}, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic [OP_W-1:0] o, input logic [XLEN-1:0] im,
                           input logic [XLEN-1:0] p, input logic [ROB_W-1:0] rp,
                           input logic b1, input logic [ROB_W-1:0] q1, input logic [XLEN-1:0] v1,
                           input logic b2, input logic [ROB_W-1:0] q2, input logic [XLEN-1:0] v2);
        dec_valid = 1'b1; dec_op = o; dec_imm = im; dec_pc = p; dec_robpos = rp;
        dec_q1_busy = b1; dec_q1 = q1; dec_v1 = v1;
        dec_q2_busy = b2; dec_q2 = q2; dec_v2 = v2;
    endtask

    task automatic push_exp(input logic [OP_W-1:0] o, input logic [ROB_W-1:0] rp,
                            input logic [XLEN-1:0] p, input logic [XLEN-1:0] im,
                            input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2);
        exp_q.push_back({o, rp, p, im, r1, r2});
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        tick();
        tick();
        chk("reset_work", {31'd0, work}, 32'd0);
        chk("reset_full", {31'd0, rs_full}, 32'd0);
        chk("reset_rs1", rs1, 32'd0);
        chk("reset_pc", pc, 32'd0);
        reset = 1'b0;

        // Operands ready at dispatch: issue after the second edge
        push_exp(OP_ADD, 4'd3, 32'h100, 32'h0, 32'd5, 32'd7);
        set_dec(OP_ADD, 32'h0, 32'h100, 4'd3, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7);
        tick();
        dec_valid = 1'b0;
        chk("add_no_bypass", {31'd0, work}, 32'd0);
        tick();
        chk("add_work", {31'd0, work}, 32'd1);
        chk("add_robpos", {28'd0, robpos}, 32'd3);
        tick();
        chk("add_pulse_end", {31'd0, work}, 32'd0);

        // Waiting rs1 woken by the ALU bus
        push_exp(OP_BEQ, 4'd4, 32'h200, 32'h10, 32'd9, 32'd11);
        set_dec(OP_BEQ, 32'h10, 32'h200, 4'd4, 1'b1, 4'd2, 32'hBAD, 1'b0, 4'd0, 32'd11);
        tick();
        dec_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("beq_wait", {31'd0, work}, 32'd0);
        end
        alu_flag = 1'b1; alu_robpos = 4'd2; alu_val = 32'd9;
        tick();
        alu_flag = 1'b0;
        chk("beq_wake_edge", {31'd0, work}, 32'd0);
        tick();
        chk("beq_issue", {31'd0, work}, 32'd1);
        chk("beq_rs1", rs1, 32'd9);
        tick();

        // Dispatch forwarding from the load/store bus
        push_exp(OP_SUB, 4'd6, 32'h300, 32'h0, 32'd1, 32'hDEAD);
        set_dec(OP_SUB, 32'h0, 32'h300, 4'd6, 1'b0, 4'd0, 32'd1, 1'b1, 4'd5, 32'd0);
        lsb_flag = 1'b1; lsb_robpos = 4'd5; lsb_val = 32'hDEAD;
        tick();
        dec_valid = 1'b0; lsb_flag = 1'b0;
        tick();
        chk("fwd_issue", {31'd0, work}, 32'd1);
        chk("fwd_rs2", rs2, 32'hDEAD);
        tick();

        // Fill all entries waiting on tag 1, then one broadcast drains them in index order
        for (int i = 0; i < 16; i++) begin
            set_dec(OP_JAL, 32'(i), 32'h1000 + 32'(4 * i), 4'(i), 1'b1, 4'd1, 32'd0, 1'b0, 4'd0, 32'(i));
            push_exp(OP_JAL, 4'(i), 32'h1000 + 32'(4 * i), 32'(i), 32'h77, 32'(i));
            tick();
        end
        chk("full_set", {31'd0, rs_full}, 32'd1);
        set_dec(OP_ADD, 32'h0, 32'hF00, 4'd0, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2);
        tick();
        dec_valid = 1'b0;
        chk("full_ignore", {31'd0, rs_full}, 32'd1);
        chk("full_no_issue", {31'd0, work}, 32'd0);
        alu_flag = 1'b1; alu_robpos = 4'd1; alu_val = 32'h77;
        tick();
        alu_flag = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("drain_work", {31'd0, work}, 32'd1);
            chk("drain_order", {28'd0, robpos}, 32'(k));
            if (k == 0) chk("full_drop", {31'd0, rs_full}, 32'd0);
        end
        tick();
        chk("drain_end", {31'd0, work}, 32'd0);

        // Flush beats dispatch, wakeup and issue
        for (int i = 0; i < 4; i++) begin
            set_dec(OP_ADD, 32'h0, 32'h2000, 4'(8 + i), 1'b1, 4'd7, 32'd0, 1'b0, 4'd0, 32'd0);
            tick();
        end
        set_dec(OP_ADD, 32'h0, 32'h3000, 4'd12, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2);
        flush = 1'b1;
        alu_flag = 1'b1; alu_robpos = 4'd7; alu_val = 32'h55;
        tick();
        flush = 1'b0; dec_valid = 1'b0;
        chk("flush_work", {31'd0, work}, 32'd0);
        chk("flush_full", {31'd0, rs_full}, 32'd0);
        tick();
        alu_flag = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("flush_no_issue", {31'd0, work}, 32'd0);
        end

        // ready low freezes everything, including a high work
        push_exp(OP_ADD, 4'd13, 32'h400, 32'h0, 32'd21, 32'd22);
        set_dec(OP_ADD, 32'h0, 32'h400, 4'd13, 1'b0, 4'd0, 32'd21, 1'b0, 4'd0, 32'd22);
        tick();
        push_exp(OP_SUB, 4'd14, 32'h404, 32'h0, 32'd31, 32'd32);
        set_dec(OP_SUB, 32'h0, 32'h404, 4'd14, 1'b0, 4'd0, 32'd31, 1'b0, 4'd0, 32'd32);
        tick();
        chk("hold_pre_work", {31'd0, work}, 32'd1);
        ready = 1'b0;
        set_dec(OP_JAL, 32'h0, 32'h408, 4'd15, 1'b0, 4'd0, 32'd41, 1'b0, 4'd0, 32'd42);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_work", {31'd0, work}, 32'd1);
            chk("hold_robpos", {28'd0, robpos}, 32'd13);
        end
        ready = 1'b1;
        dec_valid = 1'b0;
        tick();
        chk("resume_issue", {31'd0, work}, 32'd1);
        chk("resume_robpos", {28'd0, robpos}, 32'd14);
        tick();
        chk("resume_end", {31'd0, work}, 32'd0);
        tick();
        tick();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
